// File: rtl/writeback_queue_if.sv
// Writeback queue bus: producer offers (LSU, ALU), register-file write port,
// pending-register queries and occupancy status.
//   slave  : the queue itself (takes i* signals, drives o* signals)
//   master : the environment (producers, register file, issue logic)
// Ports carried:
//   iLsuValid/iLsuAddress/iLsuData, oLsuReady  LSU writeback offer
//   iAluValid/iAluAddress/iAluData, oAluReady  ALU writeback offer
//   iWriteStall                                register-file port busy
//   oWriteEnable/oWriteAddress/oDataOut        register-file write port
//   iQueryAddress0/1, oPending0/1              pending-write queries
//   oCount, oFull, oEmpty                      occupancy
interface writeback_queue_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                  iLsuValid;
  logic [ADDR_WIDTH-1:0] iLsuAddress;
  logic [DATA_WIDTH-1:0] iLsuData;
  logic                  oLsuReady;

  logic                  iAluValid;
  logic [ADDR_WIDTH-1:0] iAluAddress;
  logic [DATA_WIDTH-1:0] iAluData;
  logic                  oAluReady;

  logic                  iWriteStall;
  logic                  oWriteEnable;
  logic [ADDR_WIDTH-1:0] oWriteAddress;
  logic [DATA_WIDTH-1:0] oDataOut;

  logic [ADDR_WIDTH-1:0] iQueryAddress0;
  logic [ADDR_WIDTH-1:0] iQueryAddress1;
  logic                  oPending0;
  logic                  oPending1;

  logic [CNT_W-1:0]      oCount;
  logic                  oFull;
  logic                  oEmpty;

  modport slave (
    input  iLsuValid, iLsuAddress, iLsuData,
    output oLsuReady,
    input  iAluValid, iAluAddress, iAluData,
    output oAluReady,
    input  iWriteStall,
    output oWriteEnable, oWriteAddress, oDataOut,
    input  iQueryAddress0, iQueryAddress1,
    output oPending0, oPending1,
    output oCount, oFull, oEmpty
  );

  modport master (
    output iLsuValid, iLsuAddress, iLsuData,
    input  oLsuReady,
    output iAluValid, iAluAddress, iAluData,
    input  oAluReady,
    output iWriteStall,
    input  oWriteEnable, oWriteAddress, oDataOut,
    output iQueryAddress0, iQueryAddress1,
    input  oPending0, oPending1,
    input  oCount, oFull, oEmpty
  );
endinterface

// File: rtl/writeback_queue.sv
// In-order writeback FIFO between the ALU/LSU result producers and the
// single register-file write port. Accepts up to two writes per cycle
// (LSU first, then ALU), drains one per cycle, and answers two
// "register has a queued write" queries.
// Ports:
//   Clock    rising-edge clock
//   Reset_n  asynchronous active-low reset
//   wb       writeback_queue_if slave modport (offers, write port, queries,
//            occupancy). Parameters must match those of the interface.
// DEPTH must be a power of two and at least 2.
module writeback_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = 4
) (
  input  logic              Clock,
  input  logic              Reset_n,
  writeback_queue_if.slave  wb
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [CNT_W-1:0] free_slots;
  logic             lsu_ready;
  logic             alu_ready;
  logic             lsu_push;
  logic             alu_push;
  logic             pop;
  logic [PTR_W-1:0] alu_slot;
  logic             pend0;
  logic             pend1;

  // Free space is taken before this cycle's pop, so a full queue never
  // accepts even while draining.
  assign free_slots = CNT_W'(DEPTH) - count;
  assign lsu_ready  = (free_slots >= CNT_W'(1));
  assign alu_ready  = wb.iLsuValid ? (free_slots >= CNT_W'(2))
                                   : (free_slots >= CNT_W'(1));

  // Address 0 is handshaken but dropped: it takes no slot.
  assign lsu_push = wb.iLsuValid && lsu_ready && (wb.iLsuAddress != '0);
  assign alu_push = wb.iAluValid && alu_ready && (wb.iAluAddress != '0);
  assign pop      = (count != '0) && !wb.iWriteStall;

  // ALU lands behind the LSU entry when both push in the same cycle.
  assign alu_slot = tail + PTR_W'(lsu_push);

  // Queue state and storage.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (lsu_push) begin
        mem[tail] <= '{addr: wb.iLsuAddress, data: wb.iLsuData};
      end
      if (alu_push) begin
        mem[alu_slot] <= '{addr: wb.iAluAddress, data: wb.iAluData};
      end
      tail  <= tail + PTR_W'(lsu_push) + PTR_W'(alu_push);
      head  <= head + PTR_W'(pop);
      count <= count + CNT_W'(lsu_push) + CNT_W'(alu_push) - CNT_W'(pop);
    end
  end

  // Pending lookup over occupied entries only (head .. head+count-1).
  always_comb begin
    pend0 = 1'b0;
    pend1 = 1'b0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (CNT_W'(k) < count) begin
        if (mem[head + PTR_W'(k)].addr == wb.iQueryAddress0) pend0 = 1'b1;
        if (mem[head + PTR_W'(k)].addr == wb.iQueryAddress1) pend1 = 1'b1;
      end
    end
    if (wb.iQueryAddress0 == '0) pend0 = 1'b0;
    if (wb.iQueryAddress1 == '0) pend1 = 1'b0;
  end

  assign wb.oLsuReady     = lsu_ready;
  assign wb.oAluReady     = alu_ready;
  assign wb.oWriteEnable  = pop;
  assign wb.oWriteAddress = mem[head].addr;
  assign wb.oDataOut      = mem[head].data;
  assign wb.oPending0     = pend0;
  assign wb.oPending1     = pend1;
  assign wb.oCount        = count;
  assign wb.oFull         = (count == CNT_W'(DEPTH));
  assign wb.oEmpty        = (count == '0);
endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: reset with random inputs, a vector table with
// hand-derived status expectations, a data scoreboard for write order, and
// a mid-cycle asynchronous reset sequence.
module tb_writeback_queue;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned DP = 4;

  logic Clock;
  logic Reset_n;

  writeback_queue_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) wb ();

  writeback_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .wb      (wb.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic          lv;
    logic [AW-1:0] la;
    logic [DW-1:0] ld;
    logic          av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          st;
    logic [AW-1:0] q0;
    logic [AW-1:0] q1;
    logic [2:0]    e_cnt;
    logic          e_lr;
    logic          e_ar;
    logic          e_we;
    logic          e_p0;
    logic          e_p1;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] sb [$];
  vec_t tbl [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(
    input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
    input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
    input logic st, input logic [AW-1:0] q0, input logic [AW-1:0] q1,
    input logic [2:0] cnt, input logic lr, input logic ar, input logic we,
    input logic p0, input logic p1);
    vec_t v;
    v.lv = lv; v.la = la; v.ld = ld; v.av = av; v.aa = aa; v.ad = ad;
    v.st = st; v.q0 = q0; v.q1 = q1; v.e_cnt = cnt; v.e_lr = lr;
    v.e_ar = ar; v.e_we = we; v.e_p0 = p0; v.e_p1 = p1;
    return v;
  endfunction

  // Idle-cycle shorthand.
  function automatic vec_t idle(input logic st, input logic [AW-1:0] q0,
                                input logic [AW-1:0] q1, input logic [2:0] cnt,
                                input logic lr, input logic ar, input logic we,
                                input logic p0, input logic p1);
    return mk(0, 0, 0, 0, 0, 0, st, q0, q1, cnt, lr, ar, we, p0, p1);
  endfunction

  // Entered just after a rising edge; drives, checks mid-cycle, updates the
  // scoreboard, and returns just after the next rising edge.
  task automatic step(input vec_t v);
    logic [AW+DW-1:0] e;
    wb.iLsuValid = v.lv; wb.iLsuAddress = v.la; wb.iLsuData = v.ld;
    wb.iAluValid = v.av; wb.iAluAddress = v.aa; wb.iAluData = v.ad;
    wb.iWriteStall = v.st; wb.iQueryAddress0 = v.q0; wb.iQueryAddress1 = v.q1;
    @(negedge Clock);
    chk("count",     64'(wb.oCount),       64'(v.e_cnt));
    chk("empty",     64'(wb.oEmpty),       64'(v.e_cnt == 3'd0));
    chk("full",      64'(wb.oFull),        64'(v.e_cnt == 3'd4));
    chk("lsu_ready", 64'(wb.oLsuReady),    64'(v.e_lr));
    chk("alu_ready", 64'(wb.oAluReady),    64'(v.e_ar));
    chk("wr_en",     64'(wb.oWriteEnable), 64'(v.e_we));
    chk("pending0",  64'(wb.oPending0),    64'(v.e_p0));
    chk("pending1",  64'(wb.oPending1),    64'(v.e_p1));
    if (v.e_we) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", 64'(wb.oWriteAddress), 64'(e[AW+DW-1:DW]));
        chk("wr_data", 64'(wb.oDataOut),      64'(e[DW-1:0]));
      end
    end
    if (v.lv && v.e_lr && v.la != '0) sb.push_back({v.la, v.ld});
    if (v.av && v.e_ar && v.aa != '0) sb.push_back({v.aa, v.ad});
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0;
    // Reset held with random inputs: outputs stay at reset values.
    for (int i = 0; i < 4; i++) begin
      wb.iLsuValid = 1'($urandom); wb.iLsuAddress = AW'($urandom); wb.iLsuData = DW'($urandom);
      wb.iAluValid = 1'($urandom); wb.iAluAddress = AW'($urandom); wb.iAluData = DW'($urandom);
      wb.iWriteStall = 1'($urandom);
      wb.iQueryAddress0 = AW'($urandom); wb.iQueryAddress1 = AW'($urandom);
      @(negedge Clock);
      chk("rst_wr_en",  64'(wb.oWriteEnable),  64'(0));
      chk("rst_waddr",  64'(wb.oWriteAddress), 64'(0));
      chk("rst_wdata",  64'(wb.oDataOut),      64'(0));
      chk("rst_count",  64'(wb.oCount),        64'(0));
      chk("rst_empty",  64'(wb.oEmpty),        64'(1));
      chk("rst_full",   64'(wb.oFull),         64'(0));
      chk("rst_pend",   64'({wb.oPending0, wb.oPending1}), 64'(0));
      chk("rst_ready",  64'({wb.oLsuReady, wb.oAluReady}), 64'(2'b11));
      @(posedge Clock);
      #1;
    end
    Reset_n = 1'b1;

    // Single ALU write.
    tbl.push_back(mk(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 5, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(idle(0, 5, 0, 1, 1, 1, 1, 1, 0));
    tbl.push_back(idle(0, 5, 0, 0, 1, 1, 0, 0, 0));
    // Dual push to the same register, order preserved.
    tbl.push_back(mk(1, 3, 32'h11, 1, 3, 32'h22, 1, 3, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(idle(0, 3, 0, 2, 1, 1, 1, 1, 0));
    tbl.push_back(idle(0, 3, 0, 1, 1, 1, 1, 1, 0));
    tbl.push_back(idle(0, 3, 0, 0, 1, 1, 0, 0, 0));
    // Fill with stall held, back-pressure at count 3 and 4, pointers wrap.
    tbl.push_back(mk(1, 1, 32'hA1, 1, 2, 32'hA2, 1, 1, 2, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4, 32'hA4, 1, 1, 2, 2, 1, 1, 0, 1, 1));
    tbl.push_back(mk(1, 6, 32'hA6, 1, 9, 32'hA9, 1, 4, 9, 3, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 10, 32'hB0, 1, 11, 32'hB1, 1, 6, 9, 4, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 10, 32'hB0, 1, 11, 32'hB1, 0, 6, 1, 4, 0, 0, 1, 1, 1));
    tbl.push_back(idle(0, 1, 2, 3, 1, 1, 1, 0, 1));
    tbl.push_back(idle(0, 4, 6, 2, 1, 1, 1, 1, 1));
    tbl.push_back(idle(0, 6, 4, 1, 1, 1, 1, 1, 0));
    tbl.push_back(idle(0, 6, 0, 0, 1, 1, 0, 0, 0));
    // Address 0 handshaken but not queued.
    tbl.push_back(mk(0, 0, 0, 1, 0, 32'h55, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(idle(0, 0, 0, 0, 1, 1, 0, 0, 0));
    // Pending: not visible in acceptance cycle, query 0/8 never match.
    tbl.push_back(mk(0, 0, 0, 1, 7, 32'h77, 1, 7, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(idle(1, 7, 0, 1, 1, 1, 0, 1, 0));
    tbl.push_back(idle(1, 8, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(idle(0, 7, 0, 1, 1, 1, 1, 1, 0));
    tbl.push_back(idle(0, 7, 0, 0, 1, 1, 0, 0, 0));
    // Push and pop together at count 1.
    tbl.push_back(mk(0, 0, 0, 1, 12, 32'hC0, 1, 12, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 13, 32'hD0, 0, 0, 0, 0, 13, 12, 1, 1, 1, 1, 0, 1));
    tbl.push_back(idle(1, 13, 12, 1, 1, 1, 0, 1, 0));
    tbl.push_back(idle(0, 13, 12, 1, 1, 1, 1, 1, 0));
    tbl.push_back(idle(0, 13, 12, 0, 1, 1, 0, 0, 0));
    // Three entries queued for the reset sequence.
    tbl.push_back(mk(1, 14, 32'hE1, 1, 15, 32'hE2, 1, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 16, 32'hE3, 1, 14, 16, 2, 1, 1, 0, 1, 0));

    foreach (tbl[i]) step(tbl[i]);

    // Asynchronous reset mid-drain.
    wb.iLsuValid = 1'b0; wb.iAluValid = 1'b0; wb.iWriteStall = 1'b0;
    wb.iQueryAddress0 = 5'd14; wb.iQueryAddress1 = 5'd16;
    chk("pre_rst_count", 64'(wb.oCount), 64'(3));
    #1 Reset_n = 1'b0;
    #1;
    chk("arst_count", 64'(wb.oCount),       64'(0));
    chk("arst_wr_en", 64'(wb.oWriteEnable), 64'(0));
    chk("arst_empty", 64'(wb.oEmpty),       64'(1));
    chk("arst_pend",  64'({wb.oPending0, wb.oPending1}), 64'(0));
    #1 Reset_n = 1'b1;
    sb.delete();
    @(negedge Clock);
    chk("post_rst_wr_en", 64'(wb.oWriteEnable), 64'(0));
    @(posedge Clock);
    #1;
    chk("post_rst_count", 64'(wb.oCount), 64'(0));

    // Normal operation resumes.
    step(mk(0, 0, 0, 1, 17, 32'hF0, 0, 17, 0, 0, 1, 1, 0, 0, 0));
    step(idle(0, 17, 0, 1, 1, 1, 1, 1, 0));
    step(idle(0, 17, 0, 0, 1, 1, 0, 0, 0));
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
